// File: rtl/memory_4_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_4_port_arbiter
// Description : Upstream scheduler for a 4-to-1 shared single-port memory
//               wrapper. Four requesters issue read/write beats; at most one
//               beat is granted per cycle, round-robin between ports, with
//               burst locking (bounded by MAX_BURST). The granted beat drives
//               exactly one of the wrapper's mem_k_wr_en / mem_k_rd_en
//               enables. Read data is passed through from the wrapper with a
//               registered per-port valid pulse one cycle after the grant.
// Ports       : clk, rst               clock, synchronous active-high reset
//               port_k_req/we/addr/din/last   requester k beat (k = 0..3)
//               port_k_gnt             beat accepted this cycle (comb.)
//               port_k_rd_valid        rd_data holds port k read result
//               rd_data                pass-through of mem_dout
//               addr_err               sticky out-of-range beat flag
//               mem_k_wr_en/wr_addr/din, mem_k_rd_en/rd_addr  wrapper side
//               mem_dout               wrapper read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_4_port_arbiter #(
    parameter int WIDTH                = 64,
    parameter int SINGLE_MEM_DEPTH     = 7,
    parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
    parameter int MAX_BURST            = 8,
    parameter int MAX_BURST_LOG        = $clog2(MAX_BURST + 1)
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            port_0_req,
    input  logic                            port_0_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] port_0_addr,
    input  logic [WIDTH-1:0]                port_0_din,
    input  logic                            port_0_last,
    output logic                            port_0_gnt,
    output logic                            port_0_rd_valid,

    input  logic                            port_1_req,
    input  logic                            port_1_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] port_1_addr,
    input  logic [WIDTH-1:0]                port_1_din,
    input  logic                            port_1_last,
    output logic                            port_1_gnt,
    output logic                            port_1_rd_valid,

    input  logic                            port_2_req,
    input  logic                            port_2_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] port_2_addr,
    input  logic [WIDTH-1:0]                port_2_din,
    input  logic                            port_2_last,
    output logic                            port_2_gnt,
    output logic                            port_2_rd_valid,

    input  logic                            port_3_req,
    input  logic                            port_3_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] port_3_addr,
    input  logic [WIDTH-1:0]                port_3_din,
    input  logic                            port_3_last,
    output logic                            port_3_gnt,
    output logic                            port_3_rd_valid,

    output logic [WIDTH-1:0]                rd_data,
    output logic                            addr_err,

    output logic                            mem_0_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_wr_addr,
    output logic [WIDTH-1:0]                mem_0_din,
    output logic                            mem_0_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_0_rd_addr,

    output logic                            mem_1_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_wr_addr,
    output logic [WIDTH-1:0]                mem_1_din,
    output logic                            mem_1_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_1_rd_addr,

    output logic                            mem_2_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_wr_addr,
    output logic [WIDTH-1:0]                mem_2_din,
    output logic                            mem_2_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_2_rd_addr,

    output logic                            mem_3_wr_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_3_wr_addr,
    output logic [WIDTH-1:0]                mem_3_din,
    output logic                            mem_3_rd_en,
    output logic [SINGLE_MEM_DEPTH_LOG-1:0] mem_3_rd_addr,

    input  logic [WIDTH-1:0]                mem_dout
);

    localparam int AW = SINGLE_MEM_DEPTH_LOG;
    localparam int BW = MAX_BURST_LOG;

    localparam logic [0:0]    S_IDLE      = 1'b0;
    localparam logic [0:0]    S_LOCK      = 1'b1;

    // One extra bit so a power-of-two depth is still representable.
    localparam logic [AW:0]   c_depth     = SINGLE_MEM_DEPTH[AW:0];
    localparam logic [BW-1:0] c_max_burst = MAX_BURST[BW-1:0];
    localparam logic [BW-1:0] c_one       = {{(BW-1){1'b0}}, 1'b1};
    localparam bit            c_burst_en  = (MAX_BURST > 1);

    // ------------------------------------------------------------------
    // Gather per-port inputs into indexable form
    // ------------------------------------------------------------------
    logic [3:0]       w_req;
    logic [3:0]       w_we;
    logic [3:0]       w_last;
    logic [AW-1:0]    w_addr [4];
    logic [WIDTH-1:0] w_din  [4];

    assign w_req  = {port_3_req,  port_2_req,  port_1_req,  port_0_req};
    assign w_we   = {port_3_we,   port_2_we,   port_1_we,   port_0_we};
    assign w_last = {port_3_last, port_2_last, port_1_last, port_0_last};

    assign w_addr[0] = port_0_addr;
    assign w_addr[1] = port_1_addr;
    assign w_addr[2] = port_2_addr;
    assign w_addr[3] = port_3_addr;
    assign w_din[0]  = port_0_din;
    assign w_din[1]  = port_1_din;
    assign w_din[2]  = port_2_din;
    assign w_din[3]  = port_3_din;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [1:0]    r_rr_ptr;
    logic [1:0]    r_owner;
    logic [BW-1:0] r_beat_cnt;
    logic [3:0]    r_rd_valid;
    logic          r_addr_err;

    logic [0:0]    w_state_nxt;
    logic [1:0]    w_rr_ptr_nxt;
    logic [1:0]    w_owner_nxt;
    logic [BW-1:0] w_beat_cnt_nxt;
    logic [BW-1:0] w_beat_inc;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic          w_win_valid;
    logic [1:0]    w_win;
    logic [1:0]    w_scan;
    logic          w_grant;
    logic [3:0]    w_gnt;
    logic          w_gnt_we;
    logic          w_gnt_last;
    logic [AW-1:0] w_gnt_addr;
    logic          w_in_range;
    logic [3:0]    w_en;
    logic [3:0]    w_wr_en;
    logic [3:0]    w_rd_en;

    always_comb begin
        w_win_valid = 1'b0;
        w_win       = 2'd0;
        w_scan      = 2'd0;
        if (r_state == S_IDLE) begin
            // Scan starts just after the last winner, so it becomes lowest priority.
            for (int i = 1; i <= 4; i++) begin
                w_scan = r_rr_ptr + i[1:0];
                if (!w_win_valid && w_req[w_scan]) begin
                    w_win_valid = 1'b1;
                    w_win       = w_scan;
                end
            end
        end else if (w_req[r_owner]) begin
            w_win_valid = 1'b1;
            w_win       = r_owner;
        end
    end

    assign w_grant    = w_win_valid & ~rst;
    assign w_gnt      = w_grant ? (4'b0001 << w_win) : 4'b0000;
    assign w_gnt_we   = w_we[w_win];
    assign w_gnt_last = w_last[w_win];
    assign w_gnt_addr = w_addr[w_win];
    assign w_in_range = ({1'b0, w_gnt_addr} < c_depth);

    // Out-of-range beats are still granted (they consume a burst slot) but
    // never reach the memory.
    assign w_en    = w_gnt & {4{w_in_range}};
    assign w_wr_en = w_en  & {4{w_gnt_we}};
    assign w_rd_en = w_en  & {4{~w_gnt_we}};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign w_beat_inc = r_beat_cnt + c_one;

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (!w_gnt_last && c_burst_en) begin
                        w_state_nxt    = S_LOCK;
                        w_owner_nxt    = w_win;
                        w_beat_cnt_nxt = c_one;
                    end else begin
                        w_rr_ptr_nxt   = w_win;
                    end
                end
            end
            S_LOCK: begin
                // Owner not requesting: bubble cycle, lock is held.
                if (w_grant) begin
                    if (w_gnt_last || (w_beat_inc == c_max_burst)) begin
                        w_state_nxt    = S_IDLE;
                        w_rr_ptr_nxt   = r_owner;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = w_beat_inc;
                    end
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 2'd3;
            r_owner    <= 2'd0;
            r_beat_cnt <= '0;
            r_rd_valid <= 4'b0000;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rd_valid <= w_rd_en;
            if (w_grant && !w_in_range) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign port_0_gnt = w_gnt[0];
    assign port_1_gnt = w_gnt[1];
    assign port_2_gnt = w_gnt[2];
    assign port_3_gnt = w_gnt[3];

    // Gating with rst kills a read tag that was captured the cycle before
    // reset was asserted.
    assign port_0_rd_valid = r_rd_valid[0] & ~rst;
    assign port_1_rd_valid = r_rd_valid[1] & ~rst;
    assign port_2_rd_valid = r_rd_valid[2] & ~rst;
    assign port_3_rd_valid = r_rd_valid[3] & ~rst;

    assign rd_data  = mem_dout;
    assign addr_err = r_addr_err;

    assign mem_0_wr_en   = w_wr_en[0];
    assign mem_0_wr_addr = w_wr_en[0] ? w_addr[0] : '0;
    assign mem_0_din     = w_wr_en[0] ? w_din[0]  : '0;
    assign mem_0_rd_en   = w_rd_en[0];
    assign mem_0_rd_addr = w_rd_en[0] ? w_addr[0] : '0;

    assign mem_1_wr_en   = w_wr_en[1];
    assign mem_1_wr_addr = w_wr_en[1] ? w_addr[1] : '0;
    assign mem_1_din     = w_wr_en[1] ? w_din[1]  : '0;
    assign mem_1_rd_en   = w_rd_en[1];
    assign mem_1_rd_addr = w_rd_en[1] ? w_addr[1] : '0;

    assign mem_2_wr_en   = w_wr_en[2];
    assign mem_2_wr_addr = w_wr_en[2] ? w_addr[2] : '0;
    assign mem_2_din     = w_wr_en[2] ? w_din[2]  : '0;
    assign mem_2_rd_en   = w_rd_en[2];
    assign mem_2_rd_addr = w_rd_en[2] ? w_addr[2] : '0;

    assign mem_3_wr_en   = w_wr_en[3];
    assign mem_3_wr_addr = w_wr_en[3] ? w_addr[3] : '0;
    assign mem_3_din     = w_wr_en[3] ? w_din[3]  : '0;
    assign mem_3_rd_en   = w_rd_en[3];
    assign mem_3_rd_addr = w_rd_en[3] ? w_addr[3] : '0;

endmodule
`default_nettype wire

// File: tb/tb_memory_4_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_4_port_arbiter
// Description : Directed self-checking bench for memory_4_port_arbiter
//               (MAX_BURST = 4) with a small behavioural wrapper memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_4_port_arbiter;

    localparam int WIDTH = 64;
    localparam int AW    = 3;

    logic clk;
    logic rst;

    logic [3:0]            req;
    logic [3:0]            we;
    logic [3:0]            last;
    logic [3:0][AW-1:0]    addr;
    logic [3:0][WIDTH-1:0] din;

    wire  [3:0]            gnt;
    wire  [3:0]            rd_valid;
    wire  [WIDTH-1:0]      rd_data;
    wire                   addr_err;
    wire  [3:0]            wr_en;
    wire  [3:0]            rd_en;
    wire  [3:0][AW-1:0]    wr_addr;
    wire  [3:0][AW-1:0]    rd_addr;
    wire  [3:0][WIDTH-1:0] mdin;
    logic [WIDTH-1:0]      mem_dout;

    int n_total;
    int n_bad;

    logic [3:0] exp_rr [6];
    logic [3:0] prev_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_4_port_arbiter #(
        .WIDTH(WIDTH), .SINGLE_MEM_DEPTH(7), .SINGLE_MEM_DEPTH_LOG(AW),
        .MAX_BURST(4), .MAX_BURST_LOG(3)
    ) dut (
        .clk(clk), .rst(rst),
        .port_0_req(req[0]), .port_0_we(we[0]), .port_0_addr(addr[0]), .port_0_din(din[0]),
        .port_0_last(last[0]), .port_0_gnt(gnt[0]), .port_0_rd_valid(rd_valid[0]),
        .port_1_req(req[1]), .port_1_we(we[1]), .port_1_addr(addr[1]), .port_1_din(din[1]),
        .port_1_last(last[1]), .port_1_gnt(gnt[1]), .port_1_rd_valid(rd_valid[1]),
        .port_2_req(req[2]), .port_2_we(we[2]), .port_2_addr(addr[2]), .port_2_din(din[2]),
        .port_2_last(last[2]), .port_2_gnt(gnt[2]), .port_2_rd_valid(rd_valid[2]),
        .port_3_req(req[3]), .port_3_we(we[3]), .port_3_addr(addr[3]), .port_3_din(din[3]),
        .port_3_last(last[3]), .port_3_gnt(gnt[3]), .port_3_rd_valid(rd_valid[3]),
        .rd_data(rd_data), .addr_err(addr_err),
        .mem_0_wr_en(wr_en[0]), .mem_0_wr_addr(wr_addr[0]), .mem_0_din(mdin[0]),
        .mem_0_rd_en(rd_en[0]), .mem_0_rd_addr(rd_addr[0]),
        .mem_1_wr_en(wr_en[1]), .mem_1_wr_addr(wr_addr[1]), .mem_1_din(mdin[1]),
        .mem_1_rd_en(rd_en[1]), .mem_1_rd_addr(rd_addr[1]),
        .mem_2_wr_en(wr_en[2]), .mem_2_wr_addr(wr_addr[2]), .mem_2_din(mdin[2]),
        .mem_2_rd_en(rd_en[2]), .mem_2_rd_addr(rd_addr[2]),
        .mem_3_wr_en(wr_en[3]), .mem_3_wr_addr(wr_addr[3]), .mem_3_din(mdin[3]),
        .mem_3_rd_en(rd_en[3]), .mem_3_rd_addr(rd_addr[3]),
        .mem_dout(mem_dout)
    );

    // Behavioural wrapper: one region per port, read data one cycle after rd_en.
    logic [WIDTH-1:0] mem [4][8];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) mem[k][wr_addr[k]] <= mdin[k];
            if (rd_en[k]) mem_dout <= mem[k][rd_addr[k]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rst  = 1'b1;
        req  = 4'hF;
        we   = 4'h0;
        last = 4'hF;
        addr = '0;
        din  = '0;

        // Reset: everything quiet despite all ports requesting.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_en",  {wr_en, rd_en}, 0);
            check("rst_rdv", rd_valid, 0);
            check("rst_err", addr_err, 0);
            next_cycle();
        end
        rst = 1'b0;

        // Round robin with single-beat reads from all ports.
        prev_gnt = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rr_gnt",   gnt, exp_rr[c]);
            check("rr_rd_en", rd_en, exp_rr[c]);
            check("rr_rdv",   rd_valid, prev_gnt);
            prev_gnt = exp_rr[c];
            next_cycle();
        end
        req = 4'h0;
        @(negedge clk);
        check("idle_gnt", gnt, 0);
        check("idle_rdv", rd_valid, 4'b0010);
        next_cycle();

        // Burst lock: port 2 writes 3 beats while port 1 waits.
        req     = 4'b0110;
        we      = 4'b0100;
        last    = 4'b0010;
        addr[1] = 3'd0;
        for (int b = 0; b < 3; b++) begin
            addr[2] = 3'(b);
            din[2]  = 64'hA0 + 64'(b);
            last[2] = (b == 2);
            @(negedge clk);
            check("burst_gnt",   gnt, 4'b0100);
            check("burst_wr_en", wr_en, 4'b0100);
            check("burst_waddr", wr_addr[2], b);
            check("burst_din",   mdin[2], 64'hA0 + 64'(b));
            next_cycle();
        end
        req = 4'b0010;
        @(negedge clk);
        check("after_burst_gnt", gnt, 4'b0010);
        check("after_burst_ren", rd_en, 4'b0010);
        check("after_burst_wen", wr_en, 0);
        next_cycle();

        // Port 1 write then read of the same address.
        we[1]   = 1'b1;
        addr[1] = 3'd5;
        din[1]  = 64'hDEAD;
        @(negedge clk);
        check("wr5_gnt",  gnt, 4'b0010);
        check("wr5_wen",  wr_en, 4'b0010);
        check("wr5_addr", wr_addr[1], 5);
        check("wr5_din",  mdin[1], 64'hDEAD);
        next_cycle();
        we[1] = 1'b0;
        @(negedge clk);
        check("rd5_gnt",  gnt, 4'b0010);
        check("rd5_ren",  rd_en, 4'b0010);
        check("rd5_addr", rd_addr[1], 5);
        check("rd5_rdv0", rd_valid, 0);
        next_cycle();
        req = 4'h0;
        @(negedge clk);
        check("rd5_rdv",  rd_valid, 4'b0010);
        check("rd5_data", rd_data, 64'hDEAD);
        check("rd5_gnt0", gnt, 0);
        next_cycle();

        // Forced release after 4 beats; port 3 joins on the second beat.
        req     = 4'b0001;
        we      = 4'b0001;
        last    = 4'b1000;
        addr[0] = 3'd3;
        din[0]  = 64'h40;
        addr[3] = 3'd1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req[3] = 1'b1;
            @(negedge clk);
            check("force_gnt", gnt, 4'b0001);
            next_cycle();
        end
        @(negedge clk);
        check("force_rel_gnt", gnt, 4'b1000);
        check("force_rel_ren", rd_en, 4'b1000);
        next_cycle();
        req[3] = 1'b0;
        @(negedge clk);
        check("relock_gnt", gnt, 4'b0001);
        next_cycle();

        // Locked to port 0: bubble while port 3 requests.
        req = 4'b1000;
        @(negedge clk);
        check("bubble_gnt", gnt, 0);
        next_cycle();

        // Out-of-range write inside the burst.
        req     = 4'b1001;
        addr[0] = 3'd7;
        @(negedge clk);
        check("oor_gnt", gnt, 4'b0001);
        check("oor_en",  {wr_en, rd_en}, 0);
        check("oor_err0", addr_err, 0);
        next_cycle();
        we[0]   = 1'b0;
        addr[0] = 3'd2;
        @(negedge clk);
        check("lock_rd_gnt",  gnt, 4'b0001);
        check("lock_rd_ren",  rd_en, 4'b0001);
        check("lock_rd_addr", rd_addr[0], 2);
        check("oor_err1",     addr_err, 1);
        next_cycle();

        // Reset while locked with a read tag pending.
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_rdv", rd_valid, 0);
        next_cycle();
        rst     = 1'b0;
        req     = 4'b1000;
        addr[3] = 3'd7;
        @(negedge clk);
        check("post_rst_gnt", gnt, 4'b1000);
        check("post_rst_en",  {wr_en, rd_en}, 0);
        check("post_rst_err", addr_err, 0);
        check("post_rst_rdv", rd_valid, 0);
        next_cycle();
        req = 4'h0;
        @(negedge clk);
        check("oor_rd_rdv", rd_valid, 0);
        check("oor_rd_err", addr_err, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
